// File: rtl/axi_ddr_init_gate.sv
// AXI4 gate between the CPU RAM port and the DDR CDC: holds traffic until DDR init completes,
// then passes it through unchanged, or answers every RAM access locally with SLVERR if init fails.
module axi_ddr_init_gate #(
    parameter int          ID_WIDTH       = 6,
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_init_done,
    input  logic                    i_init_error,

    // Slave side (from CPU)
    input  logic [ID_WIDTH-1:0]     s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [7:0]              s_awlen,
    input  logic [2:0]              s_awsize,
    input  logic [1:0]              s_awburst,
    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_wlast,
    input  logic                    s_wvalid,
    output logic                    s_wready,
    output logic [ID_WIDTH-1:0]     s_bid,
    output logic [1:0]              s_bresp,
    output logic                    s_bvalid,
    input  logic                    s_bready,
    input  logic [ID_WIDTH-1:0]     s_arid,
    input  logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic [7:0]              s_arlen,
    input  logic [2:0]              s_arsize,
    input  logic [1:0]              s_arburst,
    input  logic                    s_arvalid,
    output logic                    s_arready,
    output logic [ID_WIDTH-1:0]     s_rid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic [1:0]              s_rresp,
    output logic                    s_rlast,
    output logic                    s_rvalid,
    input  logic                    s_rready,

    // Master side (toward CDC)
    output logic [ID_WIDTH-1:0]     m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [ID_WIDTH-1:0]     m_bid,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [ID_WIDTH-1:0]     m_rid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,

    output logic [1:0]              o_state
);

    typedef enum logic [1:0] {
        GATE_WAIT  = 2'd0,
        GATE_READY = 2'd1,
        GATE_FAIL  = 2'd2
    } gate_state_t;

    typedef enum logic [1:0] {
        WR_IDLE  = 2'd0,
        WR_DRAIN = 2'd1,
        WR_RESP  = 2'd2
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_ERR  = 1'b1
    } rd_state_t;

    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam bit          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    gate_state_t           gate_state, gate_next;
    wr_state_t             wr_state, wr_next;
    rd_state_t             rd_state, rd_next;

    logic                  done_meta, done_s;
    logic                  err_meta, err_s;
    logic [31:0]           timeout_cnt;
    logic                  timeout_hit;

    logic [7:0]            wr_out, rd_out;
    logic                  rdy_aw_hs, rdy_b_hs, rdy_ar_hs, rdy_rlast_hs;
    logic                  quiescent;

    logic                  fail_aw_hs, fail_ar_hs;
    logic [ID_WIDTH-1:0]   wr_id, rd_id;
    logic [7:0]            rd_cnt;

    // Request payloads always flow through; only valid/ready are gated.
    assign m_awid    = s_awid;
    assign m_awaddr  = s_awaddr;
    assign m_awlen   = s_awlen;
    assign m_awsize  = s_awsize;
    assign m_awburst = s_awburst;
    assign m_wdata   = s_wdata;
    assign m_wstrb   = s_wstrb;
    assign m_wlast   = s_wlast;
    assign m_arid    = s_arid;
    assign m_araddr  = s_araddr;
    assign m_arlen   = s_arlen;
    assign m_arsize  = s_arsize;
    assign m_arburst = s_arburst;

    assign o_state = gate_state;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours regardless of evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_meta <= 1'b0;
            done_s    <= 1'b0;
            err_meta  <= 1'b0;
            err_s     <= 1'b0;
        end else begin
            done_meta <= i_init_done;
            done_s    <= done_meta;
            err_meta  <= i_init_error;
            err_s     <= err_meta;
        end
    end

    assign timeout_hit = TIMEOUT_EN && (timeout_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            timeout_cnt <= '0;
        end else if (TIMEOUT_EN && gate_state == GATE_WAIT && timeout_cnt != '1) begin
            timeout_cnt <= timeout_cnt + 32'd1;
        end
    end

    // Outstanding pass-through bursts; READY may only fall to FAIL when none are open.
    assign rdy_aw_hs    = (gate_state == GATE_READY) && s_awvalid && m_awready;
    assign rdy_b_hs     = (gate_state == GATE_READY) && m_bvalid && s_bready;
    assign rdy_ar_hs    = (gate_state == GATE_READY) && s_arvalid && m_arready;
    assign rdy_rlast_hs = (gate_state == GATE_READY) && m_rvalid && s_rready && m_rlast;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_out <= '0;
            rd_out <= '0;
        end else begin
            case ({rdy_aw_hs, rdy_b_hs})
                2'b10:   wr_out <= wr_out + 8'd1;
                2'b01:   wr_out <= wr_out - 8'd1;
                default: wr_out <= wr_out;
            endcase
            case ({rdy_ar_hs, rdy_rlast_hs})
                2'b10:   rd_out <= rd_out + 8'd1;
                2'b01:   rd_out <= rd_out - 8'd1;
                default: rd_out <= rd_out;
            endcase
        end
    end

    assign quiescent = (wr_out == '0) && (rd_out == '0) && !rdy_aw_hs && !rdy_ar_hs
                    && (wr_state == WR_IDLE) && (rd_state == RD_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gate_state <= GATE_WAIT;
            wr_state   <= WR_IDLE;
            rd_state   <= RD_IDLE;
            wr_id      <= '0;
            rd_id      <= '0;
            rd_cnt     <= '0;
        end else begin
            gate_state <= gate_next;
            wr_state   <= wr_next;
            rd_state   <= rd_next;
            if (fail_aw_hs) wr_id <= s_awid;
            if (fail_ar_hs) begin
                rd_id  <= s_arid;
                rd_cnt <= s_arlen;
            end else if (rd_state == RD_ERR && s_rready && rd_cnt != '0) begin
                rd_cnt <= rd_cnt - 8'd1;
            end
        end
    end

    // NOTE: every always_comb assigns defaults before any branch so no path can infer a latch.
    always_comb begin
        gate_next = gate_state;
        case (gate_state)
            GATE_WAIT: begin
                if (err_s || timeout_hit) gate_next = GATE_FAIL;
                else if (done_s)          gate_next = GATE_READY;
            end
            GATE_READY: if (err_s && quiescent) gate_next = GATE_FAIL;
            default:    gate_next = gate_state;
        endcase
    end

    assign fail_aw_hs = (gate_state == GATE_FAIL) && (wr_state == WR_IDLE) && s_awvalid;
    assign fail_ar_hs = (gate_state == GATE_FAIL) && (rd_state == RD_IDLE) && s_arvalid;

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE:  if (fail_aw_hs)           wr_next = WR_DRAIN;
            WR_DRAIN: if (s_wvalid && s_wlast)  wr_next = WR_RESP;
            WR_RESP:  if (s_bready)             wr_next = WR_IDLE;
            default:                            wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (fail_ar_hs)                   rd_next = RD_ERR;
            RD_ERR:  if (s_rready && rd_cnt == '0)     rd_next = RD_IDLE;
            default:                                   rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_bid     = wr_id;
        s_bresp   = RESP_SLVERR;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        s_rid     = rd_id;
        s_rdata   = '0;
        s_rresp   = RESP_SLVERR;
        s_rlast   = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        case (gate_state)
            GATE_READY: begin
                m_awvalid = s_awvalid;
                s_awready = m_awready;
                m_wvalid  = s_wvalid;
                s_wready  = m_wready;
                s_bvalid  = m_bvalid;
                s_bid     = m_bid;
                s_bresp   = m_bresp;
                m_bready  = s_bready;
                m_arvalid = s_arvalid;
                s_arready = m_arready;
                s_rvalid  = m_rvalid;
                s_rid     = m_rid;
                s_rdata   = m_rdata;
                s_rresp   = m_rresp;
                s_rlast   = m_rlast;
                m_rready  = s_rready;
            end
            GATE_FAIL: begin
                // Stray responses from the DDR side are swallowed.
                m_bready  = 1'b1;
                m_rready  = 1'b1;
                s_awready = (wr_state == WR_IDLE);
                s_wready  = (wr_state == WR_DRAIN);
                s_bvalid  = (wr_state == WR_RESP);
                s_arready = (rd_state == RD_IDLE);
                s_rvalid  = (rd_state == RD_ERR);
                s_rlast   = (rd_state == RD_ERR) && (rd_cnt == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_ddr_init_gate.sv
// Directed bench for axi_ddr_init_gate: WAIT stall, READY pass-through, error/timeout SLVERR
// termination, concurrent FAIL channels with back-pressure, and deferred READY->FAIL.
module tb_axi_ddr_init_gate;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        i_init_done, i_init_error;

    logic [5:0]  s_awid;   logic [31:0] s_awaddr; logic [7:0] s_awlen; logic [2:0] s_awsize;
    logic [1:0]  s_awburst; logic s_awvalid, s_awready;
    logic [63:0] s_wdata;  logic [7:0] s_wstrb; logic s_wlast, s_wvalid, s_wready;
    logic [5:0]  s_bid;    logic [1:0] s_bresp; logic s_bvalid, s_bready;
    logic [5:0]  s_arid;   logic [31:0] s_araddr; logic [7:0] s_arlen; logic [2:0] s_arsize;
    logic [1:0]  s_arburst; logic s_arvalid, s_arready;
    logic [5:0]  s_rid;    logic [63:0] s_rdata; logic [1:0] s_rresp; logic s_rlast, s_rvalid, s_rready;

    logic [5:0]  m_awid;   logic [31:0] m_awaddr; logic [7:0] m_awlen; logic [2:0] m_awsize;
    logic [1:0]  m_awburst; logic m_awvalid, m_awready;
    logic [63:0] m_wdata;  logic [7:0] m_wstrb; logic m_wlast, m_wvalid, m_wready;
    logic [5:0]  m_bid;    logic [1:0] m_bresp; logic m_bvalid, m_bready;
    logic [5:0]  m_arid;   logic [31:0] m_araddr; logic [7:0] m_arlen; logic [2:0] m_arsize;
    logic [1:0]  m_arburst; logic m_arvalid, m_arready;
    logic [5:0]  m_rid;    logic [63:0] m_rdata; logic [1:0] m_rresp; logic m_rlast, m_rvalid, m_rready;

    logic [1:0]  o_state;

    int checks = 0;
    int errors = 0;
    int cyc;

    always #5 clk = ~clk;

    axi_ddr_init_gate #(
        .ID_WIDTH(6), .ADDR_WIDTH(32), .DATA_WIDTH(64), .TIMEOUT_CYCLES(100)
    ) dut (
        .clk(clk), .rstn(rstn), .i_init_done(i_init_done), .i_init_error(i_init_error),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .o_state(o_state)
    );

    // Cycles since reset release, counted on each rising edge.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_init_done = 0; i_init_error = 0;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd3; s_awburst = 2'd1; s_awvalid = 0;
        s_wdata = '0; s_wstrb = '1; s_wlast = 0; s_wvalid = 0; s_bready = 0;
        s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd3; s_arburst = 2'd1; s_arvalid = 0;
        s_rready = 0;
        m_awready = 0; m_wready = 0; m_bid = '0; m_bresp = '0; m_bvalid = 0;
        m_arready = 0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 0; m_rvalid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 0;
        step();
        step();
        rstn = 1;
    endtask

    task automatic wait_cycle(input int n);
        while (cyc < n) step();
    endtask

    task automatic wait_state(input string tag, input logic [1:0] exp, input int limit);
        int n = 0;
        while (o_state !== exp && n < limit) begin
            step();
            n++;
        end
        check(tag, o_state, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_cnt, r_cnt;
        logic prev_b_stall, prev_r_stall, prev_rlast;
        logic [5:0] prev_bid, prev_rid;

        // ---------------- Reset values ----------------
        clear_inputs();
        step();
        step();
        check("rst_state",   o_state,   2'd0);
        check("rst_awready", s_awready, 0);
        check("rst_wready",  s_wready,  0);
        check("rst_arready", s_arready, 0);
        check("rst_bvalid",  s_bvalid,  0);
        check("rst_rvalid",  s_rvalid,  0);
        check("rst_mvalid",  {m_awvalid, m_wvalid, m_arvalid}, 3'b000);
        check("rst_mready",  {m_bready, m_rready}, 2'b00);

        // ---------------- A: stall in WAIT, release at init_done ----------------
        do_reset();
        wait_cycle(40);
        s_awvalid = 1; s_awid = 6'd3; s_awaddr = 32'h8000_0100; s_awlen = 8'd0;
        s_wvalid = 1; s_wlast = 1; s_wdata = 64'hDEAD_BEEF_0000_1111;
        m_awready = 1; m_wready = 1;
        wait_cycle(45);
        check("wait_awready", s_awready, 0);
        check("wait_wready",  s_wready,  0);
        check("wait_m_valid", {m_awvalid, m_wvalid}, 2'b00);
        wait_cycle(50);
        i_init_done = 1;
        wait_state("ready_reached", 2'd1, 20);
        check("ready_cycle", (cyc >= 52 && cyc <= 53), 1);
        check("pt_awready", s_awready, 1);
        check("pt_awvalid", m_awvalid, 1);
        check("pt_awaddr",  m_awaddr,  32'h8000_0100);
        check("pt_wdata",   m_wdata,   64'hDEAD_BEEF_0000_1111);
        step();
        s_awvalid = 0; s_wvalid = 0; s_wlast = 0;
        m_bvalid = 1; m_bid = 6'd3; m_bresp = 2'b00; s_bready = 1;
        #1;
        check("pt_bvalid", s_bvalid, 1);
        check("pt_bid",    s_bid,    6'd3);
        check("pt_bresp",  s_bresp,  2'b00);
        check("pt_bready", m_bready, 1);
        step();
        m_bvalid = 0; s_bready = 0;

        s_arvalid = 1; s_arid = 6'd9; s_araddr = 32'h1000_0040; s_arlen = 8'd3; m_arready = 1;
        #1;
        check("pt_arvalid", m_arvalid, 1);
        check("pt_araddr",  m_araddr,  32'h1000_0040);
        check("pt_arid",    m_arid,    6'd9);
        check("pt_arlen",   m_arlen,   8'd3);
        check("pt_arready", s_arready, 1);
        step();
        s_arvalid = 0;
        for (int i = 0; i < 4; i++) begin
            m_rvalid = 1; m_rid = 6'd9; m_rresp = 2'b00;
            m_rdata = 64'h0123_4567_89AB_0000 + 64'(i);
            m_rlast = (i == 3); s_rready = 1;
            #1;
            check("pt_rdata",  s_rdata,  64'h0123_4567_89AB_0000 + 64'(i));
            check("pt_rlast",  s_rlast,  (i == 3));
            check("pt_rid",    s_rid,    6'd9);
            check("pt_rready", m_rready, 1);
            step();
        end
        m_rvalid = 0; m_rlast = 0; s_rready = 0;

        // ---------------- B: init_error -> SLVERR read burst ----------------
        do_reset();
        wait_cycle(30);
        i_init_error = 1;
        wait_state("err_fail", 2'd2, 20);
        check("err_fail_cycle", cyc, 33);
        s_arvalid = 1; s_arid = 6'd5; s_arlen = 8'd7; m_arready = 1;
        #1;
        check("fail_arready", s_arready, 1);
        check("fail_m_arvalid", m_arvalid, 0);
        step();
        s_arvalid = 0; s_rready = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("err_rvalid", s_rvalid, 1);
            check("err_rid",    s_rid,    6'd5);
            check("err_rresp",  s_rresp,  2'b10);
            check("err_rdata",  s_rdata,  64'd0);
            check("err_rlast",  s_rlast,  (i == 7));
            step();
        end
        #1;
        check("err_r_done", s_rvalid, 0);
        s_rready = 0;

        // ---------------- C: timeout -> SLVERR write ----------------
        do_reset();
        wait_state("to_fail", 2'd2, 200);
        check("to_cycle", (cyc >= 99 && cyc <= 101), 1);
        check("fail_mready", {m_bready, m_rready}, 2'b11);
        s_wvalid = 1; s_wlast = 0;
        #1;
        check("w_before_aw", s_wready, 0);
        step();
        s_awvalid = 1; s_awid = 6'd7; s_awlen = 8'd1; m_awready = 1;
        #1;
        check("to_awready", s_awready, 1);
        check("to_m_awvalid", m_awvalid, 0);
        step();
        s_awvalid = 0;
        #1;
        check("to_w0_ready", s_wready, 1);
        step();
        s_wlast = 1;
        #1;
        check("to_w1_ready", s_wready, 1);
        check("to_b_early", s_bvalid, 0);
        step();
        s_wvalid = 0; s_wlast = 0;
        #1;
        check("to_bvalid", s_bvalid, 1);
        check("to_bid",    s_bid,    6'd7);
        check("to_bresp",  s_bresp,  2'b10);
        check("to_wready_resp", s_wready, 0);
        s_bready = 1;
        step();
        s_bready = 0;
        #1;
        check("to_b_done", s_bvalid, 0);

        // ---------------- D: concurrent AW/AR in FAIL with back-pressure ----------------
        s_awvalid = 1; s_awid = 6'h2A; s_awlen = 8'd0;
        s_arvalid = 1; s_arid = 6'h15; s_arlen = 8'd3;
        #1;
        check("dual_awready", s_awready, 1);
        check("dual_arready", s_arready, 1);
        step();
        s_awvalid = 0; s_arvalid = 0;
        s_wvalid = 1; s_wlast = 1;
        #1;
        check("dual_wready", s_wready, 1);
        step();
        s_wvalid = 0; s_wlast = 0;
        b_cnt = 0; r_cnt = 0;
        prev_b_stall = 0; prev_r_stall = 0; prev_rlast = 0;
        prev_bid = '0; prev_rid = '0;
        for (int n = 0; n < 80 && (b_cnt < 1 || r_cnt < 4); n++) begin
            s_bready = (n < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            s_rready = (n < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            if (prev_b_stall) begin
                check("b_hold_valid", s_bvalid, 1);
                check("b_hold_id",    s_bid,    prev_bid);
            end
            if (prev_r_stall) begin
                check("r_hold_valid", s_rvalid, 1);
                check("r_hold_id",    s_rid,    prev_rid);
                check("r_hold_last",  s_rlast,  prev_rlast);
            end
            if (s_bvalid && s_bready) begin
                check("dual_bid",   s_bid,   6'h2A);
                check("dual_bresp", s_bresp, 2'b10);
                b_cnt++;
            end
            if (s_rvalid && s_rready) begin
                check("dual_rid",   s_rid,   6'h15);
                check("dual_rdata", s_rdata, 64'd0);
                check("dual_rlast", s_rlast, (r_cnt == 3));
                r_cnt++;
            end
            prev_b_stall = s_bvalid && !s_bready;
            prev_r_stall = s_rvalid && !s_rready;
            prev_bid = s_bid; prev_rid = s_rid; prev_rlast = s_rlast;
            step();
        end
        s_bready = 0; s_rready = 0;
        check("dual_b_count", b_cnt, 1);
        check("dual_r_count", r_cnt, 4);
        #1;
        check("dual_idle", {s_bvalid, s_rvalid}, 2'b00);

        // ---------------- E: error during READY with read in flight ----------------
        do_reset();
        i_init_done = 1;
        wait_state("e_ready", 2'd1, 20);
        s_arvalid = 1; s_arid = 6'd2; s_arlen = 8'd1; m_arready = 1;
        step();
        s_arvalid = 0;
        i_init_error = 1;
        repeat (6) step();
        check("e_hold_ready", o_state, 2'd1);
        m_rvalid = 1; m_rid = 6'd2; m_rlast = 0; m_rdata = 64'h5555_0000_0000_0001; s_rready = 1;
        #1;
        check("e_r0_valid", s_rvalid, 1);
        check("e_r0_data",  s_rdata,  64'h5555_0000_0000_0001);
        step();
        m_rlast = 1; m_rdata = 64'h5555_0000_0000_0002;
        #1;
        check("e_r1_last",  s_rlast, 1);
        check("e_r1_state", o_state, 2'd1);
        step();
        m_rvalid = 0; m_rlast = 0; s_rready = 0;
        check("e_still_ready", o_state, 2'd1);
        step();
        check("e_fail", o_state, 2'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
